// File: rtl/spi.sv
`default_nettype none
// ============================================================================
// Module   : spi
// Brief    : Mode-0 MSB-first SPI master with a data/control register pair;
//            8-bit slow or 32-bit fast transfers, writes stalled while busy.
// Revision : 1.0  initial release
// ============================================================================
module spi #(
    parameter int SLOW_HALF = 64,
    parameter int FAST_HALF = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic        we,
    input  logic        addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    output logic [1:0]  ss_n,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso
);

    localparam int c_MAX_HALF = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
    localparam int c_DIV_W    = $clog2(c_MAX_HALF) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [31:0]          r_tx_sh;
    logic [31:0]          r_rx_sh;
    logic [31:0]          r_rx;
    logic [2:0]           r_ctrl;
    logic [1:0]           r_ss_n;
    logic                 r_fast_lat;
    logic                 r_busy;
    logic                 r_sclk;
    logic [c_DIV_W-1:0]   r_div;
    logic [5:0]           r_bitcnt;
    logic [c_DIV_W-1:0]   w_half_m1;
    logic                 w_half_done;
    logic                 w_last;
    logic                 w_start;
    logic                 w_ctrl_wr;

    // Half-period follows the width latched at start, not the live ctrl bit.
    assign w_half_m1   = r_fast_lat ? c_DIV_W'(FAST_HALF - 1) : c_DIV_W'(SLOW_HALF - 1);
    assign w_half_done = (r_div == w_half_m1);
    assign w_last      = (r_bitcnt == 6'd1);
    assign w_start     = stb & we & ~addr & ~r_busy;
    assign w_ctrl_wr   = stb & we &  addr & ~r_busy;

    assign ack      = stb & ~rst & (~we | ~r_busy);
    assign data_out = addr       ? {31'b0, ~r_busy} :
                      r_fast_lat ? r_rx             : {24'b0, r_rx[7:0]};
    assign ss_n     = r_ss_n;
    assign sclk     = r_sclk;
    assign mosi     = (r_state == S_IDLE) ? 1'b1 : r_tx_sh[31];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start)     w_next = S_LOW;
            S_LOW:   if (w_half_done) w_next = S_HIGH;
            S_HIGH:  if (w_half_done) w_next = w_last ? S_IDLE : S_LOW;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_sh    <= 32'b0;
            r_rx_sh    <= 32'b0;
            r_rx       <= 32'b0;
            r_ctrl     <= 3'b0;
            r_ss_n     <= 2'b11;
            r_fast_lat <= 1'b0;
            r_busy     <= 1'b0;
            r_sclk     <= 1'b0;
            r_div      <= '0;
            r_bitcnt   <= 6'd0;
        end else begin
            if (w_ctrl_wr) begin
                r_ctrl <= data_in[2:0];
                r_ss_n <= ~data_in[1:0];
            end
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_fast_lat <= r_ctrl[2];
                        r_tx_sh    <= r_ctrl[2] ? data_in : {data_in[7:0], 24'b0};
                        r_bitcnt   <= r_ctrl[2] ? 6'd32 : 6'd8;
                        r_busy     <= 1'b1;
                        r_div      <= '0;
                    end
                end
                S_LOW: begin
                    if (w_half_done) begin
                        r_sclk  <= 1'b1;
                        r_rx_sh <= {r_rx_sh[30:0], miso};
                        r_div   <= '0;
                    end else begin
                        r_div <= r_div + c_DIV_W'(1);
                    end
                end
                S_HIGH: begin
                    if (w_half_done) begin
                        r_sclk   <= 1'b0;
                        r_tx_sh  <= {r_tx_sh[30:0], 1'b0};
                        r_bitcnt <= r_bitcnt - 6'd1;
                        r_div    <= '0;
                        if (w_last) begin
                            r_rx   <= r_rx_sh;
                            r_busy <= 1'b0;
                        end
                    end else begin
                        r_div <= r_div + c_DIV_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi
// Brief    : Directed and randomized bench for the spi master.
// Revision : 1.0  initial release
// ============================================================================
module tb_spi;

    localparam int SLOW_HALF = 64;
    localparam int FAST_HALF = 2;

    logic        clk = 1'b0;
    logic        rst, stb, we, addr;
    logic [31:0] data_in, data_out;
    logic        ack, sclk, mosi, miso;
    logic [1:0]  ss_n;

    logic        loop;
    logic [31:0] plan;
    int          plan_n;
    int          fall_base;
    int          k;
    logic        plan_bit;
    int          rise_cnt = 0;
    int          fall_cnt = 0;
    time         rise_t[$];
    logic        mosi_q[$];

    int          n_vec = 0;
    int          n_err = 0;
    logic        m_fast;
    logic [31:0] m_view;

    always #5 clk = ~clk;

    spi #(.SLOW_HALF(SLOW_HALF), .FAST_HALF(FAST_HALF)) dut (
        .clk(clk), .rst(rst), .stb(stb), .we(we), .addr(addr),
        .data_in(data_in), .data_out(data_out), .ack(ack),
        .ss_n(ss_n), .sclk(sclk), .mosi(mosi), .miso(miso)
    );

    always @(posedge sclk) begin
        rise_cnt++;
        rise_t.push_back($time);
        mosi_q.push_back(mosi);
    end

    always @(negedge sclk) fall_cnt++;

    // Slave model: presents plan MSB-first, one new bit after each SCLK fall.
    always_comb begin
        k        = fall_cnt - fall_base;
        plan_bit = 1'b0;
        if (k >= 0 && k < plan_n) plan_bit = plan[5'(plan_n - 1 - k)];
    end

    assign miso = loop ? mosi : plan_bit;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic a, input logic [31:0] d);
        stb = 1'b1; we = 1'b1; addr = a; data_in = d;
        #1;
        chk("wr_ack", {31'b0, ack}, 32'd1);
        @(posedge clk); #1;
        stb = 1'b0; we = 1'b0;
    endtask

    task automatic xfer(input logic fast, input logic [31:0] d, input logic lp,
                        input logic [31:0] pl);
        int          half, n, c, rb, bad_ack, bad_per;
        time         t0;
        logic [31:0] sent, exp_rx, mo;
        half = fast ? FAST_HALF : SLOW_HALF;
        n    = fast ? 32 : 8;
        sent = fast ? d : {24'b0, d[7:0]};
        exp_rx = lp ? sent : (fast ? pl : {24'b0, pl[7:0]});
        loop = lp; plan = pl; plan_n = n; fall_base = fall_cnt; rb = rise_cnt;
        stb = 1'b1; we = 1'b1; addr = 1'b0; data_in = d;
        #1;
        chk("start_ack", {31'b0, ack}, 32'd1);
        @(posedge clk); t0 = $time; #1;
        we = 1'b0; addr = 1'b1;
        #1;
        c = 0; bad_ack = 0;
        while (c < 5000 && data_out[0] !== 1'b1) begin
            if (ack !== 1'b1) bad_ack++;
            if (c == 5 && fast == m_fast) begin
                addr = 1'b0; #1;
                chk("mid_rx_view", data_out, m_view);
                addr = 1'b1; #1;
            end
            @(posedge clk); #2;
            c++;
        end
        stb = 1'b0;
        chk("xfer_len", 32'(c), 32'(2 * half * n));
        chk("read_ack_busy", 32'(bad_ack), 32'd0);
        chk("sclk_rises", 32'(rise_cnt - rb), 32'(n));
        chk("sclk_falls", 32'(fall_cnt - fall_base), 32'(n));
        mo = 32'b0; bad_per = 0;
        for (int i = 0; i < n; i++) begin
            if (rb + i < mosi_q.size()) mo = {mo[30:0], mosi_q[rb + i]};
            if (i > 0 && rb + i < rise_t.size())
                if (rise_t[rb + i] - rise_t[rb + i - 1] != time'(2 * half * 10)) bad_per++;
        end
        chk("mosi_bits", mo, sent);
        chk("sclk_period", 32'(bad_per), 32'd0);
        if (rb < rise_t.size()) chk("first_rise", 32'(rise_t[rb] - t0), 32'(half * 10));
        chk("mosi_idle", {31'b0, mosi}, 32'd1);
        addr = 1'b0; #1;
        chk("rx_data", data_out, exp_rx);
        m_fast = fast; m_view = exp_rx;
    endtask

    initial begin
        int          c;
        logic [31:0] d, pl;
        logic [1:0]  sel;
        rst = 1'b1; stb = 1'b0; we = 1'b0; addr = 1'b0; data_in = 32'b0;
        loop = 1'b1; plan = 32'b0; plan_n = 0; fall_base = 0;
        m_fast = 1'b0; m_view = 32'b0;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ss_n", {30'b0, ss_n}, 32'd3);
        chk("rst_sclk", {31'b0, sclk}, 32'd0);
        chk("rst_mosi", {31'b0, mosi}, 32'd1);
        chk("rst_ack", {31'b0, ack}, 32'd0);
        addr = 1'b1; #1;
        chk("rst_ctrl_rd", data_out, 32'h1);
        addr = 1'b0; #1;
        chk("rst_data_rd", data_out, 32'h0);

        // Slow loopback
        wr(1'b1, 32'h1);
        chk("ss_n_sd", {30'b0, ss_n}, 32'd2);
        xfer(1'b0, 32'h0000_00A5, 1'b1, 32'b0);

        // Fast loopback
        wr(1'b1, 32'h5);
        chk("ss_n_fast", {30'b0, ss_n}, 32'd2);
        xfer(1'b1, 32'hDEAD_BEEF, 1'b1, 32'b0);

        // Stall: second data write held during a fast transfer
        loop = 1'b1;
        stb = 1'b1; we = 1'b1; addr = 1'b0; data_in = 32'hCAFE_0123;
        #1;
        chk("stall_first_ack", {31'b0, ack}, 32'd1);
        @(posedge clk); #1;
        data_in = 32'h1234_5678;
        #1;
        c = 0;
        while (c < 500 && ack !== 1'b1) begin
            @(posedge clk); #2;
            c++;
        end
        chk("stall_len", 32'(c), 32'd128);
        chk("stall_first_rx", data_out, 32'hCAFE_0123);
        @(posedge clk); #1;
        stb = 1'b0; we = 1'b0; addr = 1'b1;
        #1;
        c = 0;
        while (c < 500 && data_out[0] !== 1'b1) begin
            @(posedge clk); #2;
            c++;
        end
        chk("stall_second_len", 32'(c), 32'd128);
        addr = 1'b0; #1;
        chk("stall_second_rx", data_out, 32'h1234_5678);
        m_fast = 1'b1; m_view = 32'h1234_5678;

        // Randomized transfers against the slave model
        for (int i = 0; i < 3; i++) begin
            sel = 2'($urandom_range(1, 3));
            wr(1'b1, {30'b0, sel});
            chk("rand_ss_n", {30'b0, ss_n}, {30'b0, ~sel});
            xfer(1'b0, $urandom, 1'b0, $urandom);
        end
        for (int i = 0; i < 4; i++) begin
            sel = 2'($urandom_range(1, 3));
            wr(1'b1, {29'b0, 1'b1, sel});
            xfer(1'b1, $urandom, 1'b0, $urandom);
        end

        // Mode latch: ctrl write held off by a slow transfer
        wr(1'b1, 32'h1);
        d = $urandom; pl = $urandom;
        loop = 1'b0; plan = pl; plan_n = 8; fall_base = fall_cnt;
        stb = 1'b1; we = 1'b1; addr = 1'b0; data_in = d;
        #1;
        chk("latch_start_ack", {31'b0, ack}, 32'd1);
        @(posedge clk); #1;
        addr = 1'b1; data_in = 32'h4;
        #1;
        c = 0;
        while (c < 3000 && ack !== 1'b1) begin
            @(posedge clk); #2;
            c++;
        end
        chk("latch_len", 32'(c), 32'd1024);
        chk("latch_ss_n_before", {30'b0, ss_n}, 32'd2);
        @(posedge clk); #1;
        stb = 1'b0; we = 1'b0;
        chk("latch_ss_n_after", {30'b0, ss_n}, 32'd3);
        addr = 1'b0; #1;
        chk("latch_rx", data_out, {24'b0, pl[7:0]});
        m_fast = 1'b0; m_view = {24'b0, pl[7:0]};
        xfer(1'b1, $urandom, 1'b0, $urandom);

        // Abort mid-transfer
        wr(1'b1, 32'h1);
        loop = 1'b1;
        stb = 1'b1; we = 1'b1; addr = 1'b0; data_in = $urandom;
        @(posedge clk); #1;
        stb = 1'b0; we = 1'b0;
        repeat (299) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_sclk", {31'b0, sclk}, 32'd0);
        chk("abort_ss_n", {30'b0, ss_n}, 32'd3);
        chk("abort_mosi", {31'b0, mosi}, 32'd1);
        addr = 1'b1; #1;
        chk("abort_ready", data_out, 32'h1);
        addr = 1'b0; #1;
        chk("abort_data", data_out, 32'h0);
        rst = 1'b0;
        m_fast = 1'b0; m_view = 32'h0;
        @(posedge clk); #1;

        // Recovery after abort
        wr(1'b1, 32'h2);
        chk("net_ss_n", {30'b0, ss_n}, 32'd1);
        xfer(1'b0, $urandom, 1'b0, $urandom);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
